// File: rtl/score_table_ctrl_if.sv
// Signal bundle between score_table_ctrl, the game controller, the display path and the score RAM.
interface score_table_ctrl_if #(
    parameter int unsigned SCORE_W = 7,
    parameter int unsigned ID_W    = 3
);
    logic               score_req;
    logic [ID_W-1:0]    player_id;
    logic               is_guest;
    logic [SCORE_W-1:0] score_in;
    logic               valid;
    logic               personalwin;
    logic               globalwin;
    logic [SCORE_W-1:0] global_hs;
    logic               disp_req;
    logic [ID_W-1:0]    disp_id;
    logic               disp_ack;
    logic [SCORE_W-1:0] disp_data;
    logic               busy;
    logic [ID_W-1:0]    ram_addr;
    logic [SCORE_W-1:0] ram_din;
    logic               ram_we;
    logic [SCORE_W-1:0] ram_dout;

    // Controller view
    modport slave (
        input  score_req, player_id, is_guest, score_in, disp_req, disp_id, ram_dout,
        output valid, personalwin, globalwin, global_hs, disp_ack, disp_data, busy,
               ram_addr, ram_din, ram_we
    );

    // Environment view: game controller, display path and RAM
    modport master (
        output score_req, player_id, is_guest, score_in, disp_req, disp_id, ram_dout,
        input  valid, personalwin, globalwin, global_hs, disp_ack, disp_data, busy,
               ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/score_table_ctrl.sv
// Score RAM sequencer/arbiter: score updates with personal/global record tracking and leaderboard reads.
// Define SCORE_TABLE_CLEAR_EN to zero the whole RAM after every reset (INIT walk).
module score_table_ctrl #(
    parameter int unsigned SCORE_W = 7,
    parameter int unsigned ID_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    score_table_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_DONE,
        S_DRD,
        S_DCAP
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic               guest;
        logic [SCORE_W-1:0] score;
    } upd_t;

`ifdef SCORE_TABLE_CLEAR_EN
    localparam state_e          RESET_STATE = S_INIT;
    localparam logic [ID_W-1:0] LAST_ADDR   = {ID_W{1'b1}};
`else
    localparam state_e          RESET_STATE = S_IDLE;
`endif
    localparam logic RESET_BUSY = (RESET_STATE != S_IDLE);

    state_e             state_q,     state_d;
    upd_t               req_q,       req_d;
    logic               valid_q,     valid_d;
    logic               pwin_q,      pwin_d;
    logic               gwin_q,      gwin_d;
    logic [SCORE_W-1:0] ghs_q,       ghs_d;
    logic               disp_ack_q,  disp_ack_d;
    logic [SCORE_W-1:0] disp_data_q, disp_data_d;
    logic [ID_W-1:0]    ram_addr_q,  ram_addr_d;
    logic [SCORE_W-1:0] ram_din_q,   ram_din_d;
    logic               ram_we_q,    ram_we_d;
    logic               busy_q,      busy_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            req_q       <= '0;
            valid_q     <= 1'b0;
            pwin_q      <= 1'b0;
            gwin_q      <= 1'b0;
            ghs_q       <= '0;
            disp_ack_q  <= 1'b0;
            disp_data_q <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= RESET_BUSY;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            pwin_q      <= pwin_d;
            gwin_q      <= gwin_d;
            ghs_q       <= ghs_d;
            disp_ack_q  <= disp_ack_d;
            disp_data_q <= disp_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
        end
    end

    // Next state; RAM controls are set one cycle ahead so they are live in the state that uses them
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        valid_d     = 1'b0;
        pwin_d      = pwin_q;
        gwin_d      = gwin_q;
        ghs_d       = ghs_q;
        disp_ack_d  = 1'b0;
        disp_data_d = disp_data_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;

        case (state_q)
`ifdef SCORE_TABLE_CLEAR_EN
            S_INIT: begin
                ram_din_d = '0;
                if (!ram_we_q) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = '0;
                end else if (ram_addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ID_W'(1);
                end
            end
`endif
            S_IDLE: begin
                if (bus.score_req) begin
                    req_d.id    = bus.player_id;
                    req_d.guest = bus.is_guest;
                    req_d.score = bus.score_in;
                    ram_addr_d  = bus.player_id;
                    state_d     = S_RD;
                end else if (bus.disp_req) begin
                    ram_addr_d = bus.disp_id;
                    state_d    = S_DRD;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                pwin_d = !req_q.guest && (req_q.score > bus.ram_dout);
                gwin_d = req_q.score > ghs_q;
                if (gwin_d) begin
                    ghs_d = req_q.score;
                end
                // Write-back only for a new personal record; guests never qualify
                if (pwin_d) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = req_q.id;
                    ram_din_d  = req_q.score;
                end
                state_d = S_WR;
            end
            S_WR: begin
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRD: begin
                disp_ack_d = 1'b1;
                state_d    = S_DCAP;
            end
            S_DCAP: begin
                disp_data_d = bus.ram_dout;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    assign bus.valid       = valid_q;
    assign bus.personalwin = pwin_q;
    assign bus.globalwin   = gwin_q;
    assign bus.global_hs   = ghs_q;
    assign bus.disp_ack    = disp_ack_q;
    // Read data only arrives in DCAP, so bypass the holding register while the ack is up
    assign bus.disp_data   = (state_q == S_DCAP) ? bus.ram_dout : disp_data_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.busy        = busy_q;

    a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst)
        ram_we_q |-> (state_q == S_WR || state_q == S_INIT));

    a_no_dual_pulse: assert property (@(posedge clk) disable iff (!rst)
        !(valid_q && disp_ack_q));
endmodule

// File: tb/tb_score_table_ctrl.sv
// Scoreboard bench for score_table_ctrl: directed updates/reads, RAM write tracking, mid-update reset.
`timescale 1ns/1ps
module tb_score_table_ctrl;
    localparam int unsigned SCORE_W = 7;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned DEPTH   = 1 << ID_W;

    typedef struct {
        bit is_disp;
        bit pwin;
        bit gwin;
        int ghs;
        int data;
        int cyc;
    } exp_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    wr_t  wr_q[$];
    logic [SCORE_W-1:0] mem [DEPTH] = '{default: '0};

    score_table_ctrl_if #(.SCORE_W(SCORE_W), .ID_W(ID_W)) bus ();

    score_table_ctrl #(.SCORE_W(SCORE_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read score RAM
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a result or a read
    always @(negedge clk) begin : mon
        exp_t e;
        wr_t  w;
        if (rst) begin
            if (bus.ram_we) begin
                if (wr_q.size() == 0) chk("spurious_ram_we", int'(bus.ram_we), 0);
                else begin
                    w = wr_q.pop_front();
                    chk("ram_addr", int'(bus.ram_addr), w.addr);
                    chk("ram_din", int'(bus.ram_din), w.data);
                end
            end
            if (bus.valid) begin
                if (exp_q.size() == 0 || exp_q[0].is_disp) chk("spurious_valid", int'(bus.valid), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("personalwin", int'(bus.personalwin), int'(e.pwin));
                    chk("globalwin", int'(bus.globalwin), int'(e.gwin));
                    chk("global_hs", int'(bus.global_hs), e.ghs);
                    chk("valid_cycle", cyc, e.cyc);
                end
            end
            if (bus.disp_ack) begin
                if (exp_q.size() == 0 || !exp_q[0].is_disp) chk("spurious_disp_ack", int'(bus.disp_ack), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("disp_data", int'(bus.disp_data), e.data);
                    chk("disp_ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            chk("drain_timeout", exp_q.size() + wr_q.size(), 0);
            exp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic send_upd(input int id, input bit guest, input int score,
                            input bit pw, input bit gw, input int ghs);
        exp_t e;
        wr_t  w;
        e = '{is_disp: 1'b0, pwin: pw, gwin: gw, ghs: ghs, data: 0, cyc: cyc + 4};
        exp_q.push_back(e);
        if (pw) begin
            w = '{addr: id, data: score};
            wr_q.push_back(w);
        end
        bus.score_req = 1'b1;
        bus.player_id = ID_W'(id);
        bus.is_guest  = guest;
        bus.score_in  = SCORE_W'(score);
        tick();
        bus.score_req = 1'b0;
    endtask

    task automatic disp_read(input int id, input int data);
        exp_t e;
        e = '{is_disp: 1'b1, pwin: 1'b0, gwin: 1'b0, ghs: 0, data: data, cyc: cyc + 2};
        exp_q.push_back(e);
        bus.disp_req = 1'b1;
        bus.disp_id  = ID_W'(id);
        wait_drain(20);
        bus.disp_req = 1'b0;
    endtask

    task automatic push_init_writes();
`ifdef SCORE_TABLE_CLEAR_EN
        wr_t w;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = '{addr: i, data: 0};
            wr_q.push_back(w);
        end
`endif
    endtask

    task automatic check_reset_outputs(input int exp_busy);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_personalwin", int'(bus.personalwin), 0);
        chk("rst_globalwin", int'(bus.globalwin), 0);
        chk("rst_global_hs", int'(bus.global_hs), 0);
        chk("rst_disp_ack", int'(bus.disp_ack), 0);
        chk("rst_disp_data", int'(bus.disp_data), 0);
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_ram_din", int'(bus.ram_din), 0);
        chk("rst_ram_we", int'(bus.ram_we), 0);
        chk("rst_busy", int'(bus.busy), exp_busy);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int exp_busy;
        int exp_rd3;
        exp_t e;
`ifdef SCORE_TABLE_CLEAR_EN
        exp_busy = 1;
        exp_rd3  = 0;
`else
        exp_busy = 0;
        exp_rd3  = 42;
`endif
        bus.score_req = 1'b0;
        bus.player_id = '0;
        bus.is_guest  = 1'b0;
        bus.score_in  = '0;
        bus.disp_req  = 1'b0;
        bus.disp_id   = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs(exp_busy);
        push_init_writes();
        rst = 1'b1;
        tick();
        wait_drain(40);
        chk("busy_after_init", int'(bus.busy), 0);

        // Fresh record, tie, personal-only win, guest global win
        send_upd(3, 1'b0, 42, 1'b1, 1'b1, 42);
        chk("busy_during_update", int'(bus.busy), 1);
        wait_drain(20);
        send_upd(3, 1'b0, 42, 1'b0, 1'b0, 42);
        wait_drain(20);
        send_upd(5, 1'b0, 30, 1'b1, 1'b0, 42);
        wait_drain(20);
        chk("personalwin_held", int'(bus.personalwin), 1);
        send_upd(0, 1'b1, 100, 1'b0, 1'b1, 100);
        wait_drain(20);

        disp_read(5, 30);
        chk("disp_data_held", int'(bus.disp_data), 30);

        // Simultaneous update and read: update first, read two cycles after IDLE
        c0 = cyc;
        bus.disp_req = 1'b1;
        bus.disp_id  = ID_W'(3);
        send_upd(1, 1'b0, 50, 1'b1, 1'b0, 100);
        e = '{is_disp: 1'b1, pwin: 1'b0, gwin: 1'b0, ghs: 0, data: 42, cyc: c0 + 7};
        exp_q.push_back(e);
        wait_drain(30);
        bus.disp_req = 1'b0;

        // Back-to-back updates on the same entry and max-score boundary
        send_upd(2, 1'b0, 20, 1'b1, 1'b0, 100);
        wait_drain(20);
        send_upd(2, 1'b0, 21, 1'b1, 1'b0, 100);
        wait_drain(20);
        send_upd(7, 1'b0, 127, 1'b1, 1'b1, 127);
        wait_drain(20);
        send_upd(4, 1'b0, 127, 1'b1, 1'b0, 127);
        wait_drain(20);
        send_upd(7, 1'b0, 126, 1'b0, 1'b0, 127);
        wait_drain(20);
        chk("disp_data_kept", int'(bus.disp_data), 42);

        // Request while busy is dropped
        send_upd(0, 1'b0, 5, 1'b1, 1'b0, 127);
        bus.score_req = 1'b1;
        bus.player_id = ID_W'(1);
        bus.score_in  = SCORE_W'(126);
        tick();
        bus.score_req = 1'b0;
        wait_drain(20);

        // Reset during CMP of an update for ID 6
        bus.score_req = 1'b1;
        bus.player_id = ID_W'(6);
        bus.is_guest  = 1'b0;
        bus.score_in  = SCORE_W'(99);
        tick();
        bus.score_req = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_before_abort", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs(exp_busy);
        repeat (2) @(negedge clk);
        push_init_writes();
        rst = 1'b1;
        tick();
        wait_drain(40);
        chk("busy_after_reset", int'(bus.busy), 0);

        disp_read(6, 0);
        disp_read(3, exp_rd3);
        send_upd(6, 1'b0, 10, 1'b1, 1'b1, 10);
        wait_drain(20);

        chk("exp_q_left", exp_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
